bram_fir2_sequencer: RTL and testbench
======================================

Name: bram_fir2_sequencer

Overview:
- Controller that sequences the 1024x8 dual-port sample BRAM for a 2-tap smoothing pass.
- On start, streams LEN signed samples from a source region via port A (read-only).
- Writes y[i] = sat8(x[i] + x[i-1]) to a destination region via port B, one sample per clock.
- Reports the full-precision signed sum of all samples read. Sits between the host/control FSM and the BRAM instance.

Parameters:
- ADDR_W, 10, BRAM address width (1024 words)
- DATA_W, 8, signed sample width
- LEN_W, 11, length field width (1..1024)
- SUM_W, 18, signed accumulator width (covers 1024 x [-128,127])

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low; sampled on rising clk
- start  in  1  request new pass; sampled only in IDLE
- src_base  in  ADDR_W  first source address; latched at start
- dst_base  in  ADDR_W  first destination address; latched at start
- len  in  LEN_W  sample count; latched at start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of pass (or on error)
- err  out  1  one-cycle pulse with done when len==0 or len>1024
- sum_out  out  SUM_W  signed sum of x[0..len-1]; valid from done until next accepted start
- mem_addr_a  out  ADDR_W  port A address
- mem_we_a  out  1  tied 0
- mem_dout_a  in  DATA_W  port A read data (1-cycle synchronous latency)
- mem_addr_b  out  ADDR_W  port B address
- mem_we_b  out  1  port B write enable
- mem_din_b  out  DATA_W  port B write data

Behaviour:
- Reset (rst==0 at edge): state IDLE; busy, done, err, mem_we_b, mem_we_a = 0; sum_out, mem_addr_a/b, mem_din_b = 0; prev-sample register = 0. Reset mid-pass aborts immediately; no further writes.
- All outputs registered.
- States: IDLE, READ, DRAIN, FIN.
- IDLE: on start==1, latch src/dst/len and clear acc and prev.
  - len invalid (0 or >1024): go to FIN with err flagged. No memory access.
  - Otherwise: busy=1, go to READ, read index k=0.
  - start in any other state is ignored.
- READ: per cycle k (0..len-1), mem_addr_a = (src_base+k) mod 1024. After issuing k=len-1, go to DRAIN.
- Pipeline: data for k valid on mem_dout_a one cycle after issue.
  - Next edge: acc += sext(x); prev <= x.
  - Same edge: mem_addr_b = (dst_base+k) mod 1024, mem_din_b = sat8(x + prev), mem_we_b = 1.
  - Net: write of sample k is presented 2 cycles after its read address.
- DRAIN: 2 cycles to retire the last writes; mem_we_b drops after the last write. Then go to FIN.
- FIN: done=1 for one cycle, sum_out = acc, busy=0 in that same cycle, then IDLE.
- Latency: valid pass has done exactly len+3 cycles after the start-accept edge. Invalid pass has done/err on the cycle after accept, sum_out = 0.
- Arithmetic: x + prev computed at 9 bits signed.
  - sat8 clamps to [-128, 127].
  - acc is SUM_W signed and never wraps for len<=1024.
  - y[0] uses prev=0.
- Address wrap: src and dst indices wrap modulo 1024 independently.
- Overlap:
  - In-place (dst==src) and dst==src+1 are supported: each write lands after its address was read.
  - (dst-src) mod 1024 in [2, len-1] is unsupported; results undefined.
  - The block does not check overlap.

Test Plan:
1. mem[0..3] = {10, 20, -5, 100}, src=0, dst=512, len=4 -> mem[512..515] = {10, 30, 15, 95}; sum_out = 125; done at accept+7; one done pulse; busy high 7 cycles.
2. Saturation: src {100, 100, -100, -100, -28}, len=5 -> dst {100, 127, 0, -128, -128}; sum_out = -28.
3. Wrap: src=1022, dst=1023, len=4, mem[1022,1023,0,1] = {1, 2, 3, 4} -> mem[1023,0,1,2] = {1, 3, 5, 7}. Read-before-write order keeps inputs intact; sum = 10.
4. len=0, then len=1025 -> done and err pulse the cycle after accept; mem_we_b never asserted; sum_out = 0.
5. Full pass len=1024, all samples 127 -> dst all 127 (254 saturated, first = 127); sum_out = 130048. start pulsed mid-pass is ignored.
6. rst low during READ at k=5 -> next edge busy=0, mem_we_b=0, no done. After rst high, a new start with len=2 completes normally.

Source files
------------

// File: rtl/bram_fir2_sequencer.sv
// Sequences a 1024x8 dual-port sample BRAM for a 2-tap smoothing pass:
// reads x[k] on port A, writes sat8(x[k] + x[k-1]) on port B, and accumulates the sum of x.
module bram_fir2_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 11,
    parameter int SUM_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SUM_W-1:0]  sum_out,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic              mem_we_a,
    input  logic [DATA_W-1:0] mem_dout_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic              mem_we_b,
    output logic [DATA_W-1:0] mem_din_b
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    // Clamp a (DATA_W+1)-bit signed value into the DATA_W-bit signed range.
    function automatic logic [DATA_W-1:0] sat_sample(input logic signed [DATA_W:0] v);
        logic signed [DATA_W:0] hi;
        logic signed [DATA_W:0] lo;
        hi = $signed({2'b00, {(DATA_W-1){1'b1}}});
        lo = $signed({2'b11, {(DATA_W-1){1'b0}}});
        if (v > hi) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end else if (v < lo) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   src_r;
    logic [ADDR_W-1:0]   dst_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    rd_idx_r;
    logic [ADDR_W-1:0]   wr_idx_r;
    logic                drain_r;
    logic                v1_r;
    logic                v2_r;
    logic                err_flag_r;
    logic [DATA_W-1:0]   prev_r;
    logic [SUM_W-1:0]    acc_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [SUM_W-1:0]    sum_r;
    logic [ADDR_W-1:0]   addr_a_r;
    logic [ADDR_W-1:0]   addr_b_r;
    logic                we_b_r;
    logic [DATA_W-1:0]   din_b_r;

    logic                accept_s;
    logic                len_bad_s;
    logic                issue_s;
    logic signed [DATA_W:0] pair_sum_s;
    logic [DATA_W-1:0]   y_s;
    logic [SUM_W-1:0]    acc_next_s;

    // Next-state logic and per-cycle strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        len_bad_s = (len == {LEN_W{1'b0}}) || (len > MAX_LEN);
        issue_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = len_bad_s ? ST_FIN : ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                issue_s = 1'b1;
                if (rd_idx_r == len_r - LEN_W'(1)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (drain_r) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Filter arithmetic on the sample returning from port A.
    always_comb begin
        pair_sum_s = $signed({mem_dout_a[DATA_W-1], mem_dout_a})
                   + $signed({prev_r[DATA_W-1], prev_r});
        y_s        = sat_sample(pair_sum_s);
        acc_next_s = acc_r + {{(SUM_W-DATA_W){mem_dout_a[DATA_W-1]}}, mem_dout_a};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pass control: latched parameters, counters and host-facing status.
    always_ff @(posedge clk) begin
        if (!rst) begin
            src_r      <= {ADDR_W{1'b0}};
            dst_r      <= {ADDR_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            rd_idx_r   <= {LEN_W{1'b0}};
            drain_r    <= 1'b0;
            err_flag_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            sum_r      <= {SUM_W{1'b0}};
        end else begin
            drain_r <= (state_r == ST_DRAIN);
            if (accept_s) begin
                src_r      <= src_base;
                dst_r      <= dst_base;
                len_r      <= len;
                rd_idx_r   <= {LEN_W{1'b0}};
                err_flag_r <= len_bad_s;
                busy_r     <= ~len_bad_s;
            end else if (issue_s) begin
                rd_idx_r <= rd_idx_r + LEN_W'(1);
            end
            if (state_r == ST_FIN) begin
                done_r <= 1'b1;
                err_r  <= err_flag_r;
                sum_r  <= acc_r;
                busy_r <= 1'b0;
            end else begin
                done_r <= 1'b0;
                err_r  <= 1'b0;
            end
        end
    end

    // Memory pipeline: v1/v2 track a read in flight so the write lands two cycles after its address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_r     <= 1'b0;
            v2_r     <= 1'b0;
            addr_a_r <= {ADDR_W{1'b0}};
            addr_b_r <= {ADDR_W{1'b0}};
            we_b_r   <= 1'b0;
            din_b_r  <= {DATA_W{1'b0}};
            wr_idx_r <= {ADDR_W{1'b0}};
            prev_r   <= {DATA_W{1'b0}};
            acc_r    <= {SUM_W{1'b0}};
        end else begin
            v1_r <= issue_s;
            v2_r <= v1_r;
            if (issue_s) begin
                addr_a_r <= src_r + rd_idx_r[ADDR_W-1:0];
            end
            if (accept_s) begin
                wr_idx_r <= {ADDR_W{1'b0}};
                prev_r   <= {DATA_W{1'b0}};
                acc_r    <= {SUM_W{1'b0}};
                we_b_r   <= 1'b0;
            end else if (v2_r) begin
                acc_r    <= acc_next_s;
                prev_r   <= mem_dout_a;
                addr_b_r <= dst_r + wr_idx_r;
                din_b_r  <= y_s;
                we_b_r   <= 1'b1;
                wr_idx_r <= wr_idx_r + ADDR_W'(1);
            end else begin
                we_b_r <= 1'b0;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign sum_out    = sum_r;
    assign mem_addr_a = addr_a_r;
    assign mem_we_a   = 1'b0;
    assign mem_addr_b = addr_b_r;
    assign mem_we_b   = we_b_r;
    assign mem_din_b  = din_b_r;

endmodule

// File: tb/tb_bram_fir2_sequencer.sv
// Directed bench for bram_fir2_sequencer: a behavioural 1024x8 BRAM plus a vector
// table of passes, followed by the full-length, mid-pass start and reset corner cases.
module tb_bram_fir2_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  src_base;
    logic [9:0]  dst_base;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [17:0] sum_out;
    logic [9:0]  mem_addr_a;
    logic        mem_we_a;
    logic [7:0]  mem_dout_a;
    logic [9:0]  mem_addr_b;
    logic        mem_we_b;
    logic [7:0]  mem_din_b;

    bram_fir2_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done), .err(err), .sum_out(sum_out),
        .mem_addr_a(mem_addr_a), .mem_we_a(mem_we_a), .mem_dout_a(mem_dout_a),
        .mem_addr_b(mem_addr_b), .mem_we_b(mem_we_b), .mem_din_b(mem_din_b)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: 1-cycle read on A, write on B, plus bench-side fill/load ports.
    logic [7:0] mem [1024];
    logic       fill_en = 1'b0;
    logic [7:0] fill_val = 8'd0;
    logic       ld_en = 1'b0;
    logic [9:0] ld_addr = 10'd0;
    logic [7:0] ld_data = 8'd0;

    always @(posedge clk) begin
        mem_dout_a <= mem[mem_addr_a];
        if (fill_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= fill_val;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_we_b) begin
            mem[mem_addr_b] <= mem_din_b;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        fill_val = v;
        fill_en  = 1'b1;
        @(posedge clk); #1;
        fill_en  = 1'b0;
    endtask

    task automatic load(input logic [9:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk); #1;
        ld_en   = 1'b0;
    endtask

    int          r_done_cyc;
    int          r_busy_cyc;
    int          r_we_cnt;
    int          r_extra_done;
    logic        r_err;
    logic [17:0] r_sum;

    // Launch one pass and observe it until done (bounded); counts are taken #1 after each edge.
    task automatic run_pass(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l, input bit mid_start);
        src_base = s;
        dst_base = d;
        len      = l;
        start    = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        r_done_cyc   = 0;
        r_busy_cyc   = busy ? 1 : 0;
        r_we_cnt     = mem_we_b ? 1 : 0;
        r_extra_done = 0;
        r_err        = 1'b0;
        r_sum        = 18'd0;
        for (int c = 1; c <= 1200; c++) begin
            if (mid_start && c == 100) begin
                len   = 11'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (busy) r_busy_cyc++;
            if (mem_we_b) r_we_cnt++;
            if (done) begin
                r_done_cyc = c;
                r_err      = err;
                r_sum      = sum_out;
                break;
            end
        end
        start = 1'b0;
        if (r_done_cyc == 0) begin
            check("done_timeout", 64'sd0, 64'sd1);
        end
        @(posedge clk); #1;
        if (done) r_extra_done = 1;
    endtask

    typedef struct {
        logic [9:0]        src;
        logic [9:0]        dst;
        logic [10:0]       len;
        logic [4:0][7:0]   x;
        logic [4:0][7:0]   y;
        int                nx;
        logic signed [17:0] sum;
        logic              err;
    } vec_t;

    vec_t vecs [5];

    initial begin
        // Elements are listed x[4]..x[0].
        vecs[0] = '{src: 10'd0, dst: 10'd512, len: 11'd4, nx: 4, err: 1'b0, sum: 18'sd125,
                    x: {8'sd0, 8'sd100, -8'sd5, 8'sd20, 8'sd10},
                    y: {8'sd0, 8'sd95, 8'sd15, 8'sd30, 8'sd10}};
        vecs[1] = '{src: 10'd100, dst: 10'd700, len: 11'd5, nx: 5, err: 1'b0, sum: -18'sd28,
                    x: {-8'sd28, -8'sd100, -8'sd100, 8'sd100, 8'sd100},
                    y: {-8'sd128, -8'sd128, 8'sd0, 8'sd127, 8'sd100}};
        vecs[2] = '{src: 10'd1022, dst: 10'd1023, len: 11'd4, nx: 4, err: 1'b0, sum: 18'sd10,
                    x: {8'sd0, 8'sd4, 8'sd3, 8'sd2, 8'sd1},
                    y: {8'sd0, 8'sd7, 8'sd5, 8'sd3, 8'sd1}};
        vecs[3] = '{src: 10'd0, dst: 10'd300, len: 11'd0, nx: 0, err: 1'b1, sum: 18'sd0,
                    x: {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0},
                    y: {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0}};
        vecs[4] = '{src: 10'd0, dst: 10'd300, len: 11'd1025, nx: 0, err: 1'b1, sum: 18'sd0,
                    x: {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0},
                    y: {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0}};

        rst      = 1'b0;
        start    = 1'b0;
        src_base = 10'd0;
        dst_base = 10'd0;
        len      = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'sd0);
        check("rst_done", 64'(done), 64'sd0);
        check("rst_err", 64'(err), 64'sd0);
        check("rst_we_b", 64'(mem_we_b), 64'sd0);
        check("rst_we_a", 64'(mem_we_a), 64'sd0);
        check("rst_sum", 64'(sum_out), 64'sd0);
        check("rst_addr_a", 64'(mem_addr_a), 64'sd0);
        check("rst_din_b", 64'(mem_din_b), 64'sd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven passes.
        for (int v = 0; v < 5; v++) begin
            logic [9:0] a;
            fill(8'h5A);
            for (int i = 0; i < vecs[v].nx; i++) begin
                a = vecs[v].src + 10'(i);
                load(a, vecs[v].x[i]);
            end
            run_pass(vecs[v].src, vecs[v].dst, vecs[v].len, 1'b0);
            check($sformatf("v%0d_done_cyc", v), 64'(r_done_cyc), vecs[v].err ? 64'sd1 : 64'(vecs[v].len) + 64'sd3);
            check($sformatf("v%0d_busy_cyc", v), 64'(r_busy_cyc), vecs[v].err ? 64'sd0 : 64'(vecs[v].len) + 64'sd3);
            check($sformatf("v%0d_we_cnt", v), 64'(r_we_cnt), 64'(vecs[v].nx));
            check($sformatf("v%0d_err", v), 64'(r_err), 64'(vecs[v].err));
            check($sformatf("v%0d_sum", v), 64'($signed(r_sum)), 64'(vecs[v].sum));
            check($sformatf("v%0d_extra_done", v), 64'(r_extra_done), 64'sd0);
            for (int i = 0; i < vecs[v].nx; i++) begin
                a = vecs[v].dst + 10'(i);
                check($sformatf("v%0d_y%0d", v, i), 64'($signed(mem[a])), 64'($signed(vecs[v].y[i])));
            end
        end

        // Full-length in-place pass of saturating samples, with an ignored start mid-pass.
        begin
            int bad_words;
            fill(8'd127);
            run_pass(10'd0, 10'd0, 11'd1024, 1'b1);
            check("full_done_cyc", 64'(r_done_cyc), 64'sd1027);
            check("full_busy_cyc", 64'(r_busy_cyc), 64'sd1027);
            check("full_we_cnt", 64'(r_we_cnt), 64'sd1024);
            check("full_err", 64'(r_err), 64'sd0);
            check("full_sum", 64'($signed(r_sum)), 64'sd130048);
            check("full_extra_done", 64'(r_extra_done), 64'sd0);
            bad_words = 0;
            for (int i = 0; i < 1024; i++) if (mem[i] !== 8'd127) bad_words++;
            check("full_mem_words_wrong", 64'(bad_words), 64'sd0);
        end

        // Reset asserted while the read at k=5 is being issued.
        begin
            int late_done;
            int late_we;
            fill(8'd0);
            src_base = 10'd0;
            dst_base = 10'd512;
            len      = 11'd20;
            start    = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            check("midrst_busy_before", 64'(busy), 64'sd1);
            rst = 1'b0;
            @(posedge clk); #1;
            check("midrst_busy", 64'(busy), 64'sd0);
            check("midrst_we_b", 64'(mem_we_b), 64'sd0);
            check("midrst_done", 64'(done), 64'sd0);
            rst = 1'b1;
            late_done = 0;
            late_we   = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                if (done) late_done++;
                if (mem_we_b) late_we++;
            end
            check("midrst_late_done", 64'(late_done), 64'sd0);
            check("midrst_late_we", 64'(late_we), 64'sd0);
            load(10'd40, 8'd50);
            load(10'd41, -8'sd60);
            run_pass(10'd40, 10'd600, 11'd2, 1'b0);
            check("after_rst_done_cyc", 64'(r_done_cyc), 64'sd5);
            check("after_rst_sum", 64'($signed(r_sum)), -64'sd10);
            check("after_rst_y0", 64'($signed(mem[600])), 64'sd50);
            check("after_rst_y1", 64'($signed(mem[601])), -64'sd10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
